// File: rtl/pow_n_multi_cycle_if.sv
// Operand/result bundle for pow_n_multi_cycle.
//   n_vld   : operand valid (source -> unit)
//   n_rdy   : unit idle and able to accept (unit -> source)
//   n, e    : base (W bits) and exponent (EW bits)
//   res_vld : one enabled-cycle pulse marking a new result
//   res     : result, held until the next completion
//   ovf     : overflow flag for res, present only when POW_N_OVF_EN is defined
// The master modport is the operand source / result consumer; the slave is the unit.
interface pow_n_multi_cycle_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned EW = 4
);
  logic          n_vld;
  logic          n_rdy;
  logic [W-1:0]  n;
  logic [EW-1:0] e;
  logic          res_vld;
  logic [W-1:0]  res;
`ifdef POW_N_OVF_EN
  logic          ovf;
`endif

  modport master (
    output n_vld, n, e,
`ifdef POW_N_OVF_EN
    input  ovf,
`endif
    input  n_rdy, res_vld, res
  );

  modport slave (
    input  n_vld, n, e,
`ifdef POW_N_OVF_EN
    output ovf,
`endif
    output n_rdy, res_vld, res
  );
endinterface

// File: rtl/pow_n_multi_cycle.sv
// Multi-cycle integer power unit: res = n ** e mod 2**W.
// Square-and-multiply, one exponent bit per enabled clock; latency is bit-length(e)+1
// enabled cycles from the accepting edge.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   clk_en : global enable, every register holds while low (including res_vld)
//   bus    : pow_n_multi_cycle_if slave (n_vld/n_rdy/n/e in, res_vld/res[/ovf] out)
// Build option: define POW_N_OVF_EN to add the ovf output, which is 1 exactly when the
// true n**e does not fit in W bits.
module pow_n_multi_cycle #(
  parameter int unsigned W  = 8,
  parameter int unsigned EW = 4
) (
  input logic               clk,
  input logic               rst,
  input logic               clk_en,
  pow_n_multi_cycle_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e        state_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  base_q;
  logic [EW-1:0] exp_q;
  logic [W-1:0]  res_q;
  logic          res_vld_q;

`ifdef POW_N_OVF_EN
  logic [2*W-1:0] acc_prod;
  logic [2*W-1:0] base_sq;
  logic           ovf_flag_q;
  logic           ovf_q;
  logic           acc_ovf;
  logic           sq_ovf;

  always_comb begin
    acc_prod = {{W{1'b0}}, acc_q} * {{W{1'b0}}, base_q};
    base_sq  = {{W{1'b0}}, base_q} * {{W{1'b0}}, base_q};
    acc_ovf  = exp_q[0] && (|acc_prod[2*W-1:W]);
    // A square that overflows only matters if that base is multiplied in later.
    sq_ovf   = (|base_sq[2*W-1:W]) && ((exp_q >> 1) != '0);
  end
`else
  // Only the low half of each product is ever used without overflow tracking.
  logic [W-1:0] acc_prod;
  logic [W-1:0] base_sq;

  always_comb begin
    acc_prod = acc_q * base_q;
    base_sq  = base_q * base_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      base_q     <= '0;
      exp_q      <= '0;
      res_q      <= '0;
      res_vld_q  <= 1'b0;
`ifdef POW_N_OVF_EN
      ovf_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else if (clk_en) begin
      res_vld_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.n_vld) begin
            base_q     <= bus.n;
            acc_q      <= {{(W-1){1'b0}}, 1'b1};
            exp_q      <= bus.e;
            state_q    <= StCalc;
`ifdef POW_N_OVF_EN
            ovf_flag_q <= 1'b0;
`endif
          end
        end
        StCalc: begin
          if (exp_q != '0) begin
            if (exp_q[0]) begin
              acc_q <= acc_prod[W-1:0];
            end
            base_q <= base_sq[W-1:0];
            exp_q  <= exp_q >> 1;
`ifdef POW_N_OVF_EN
            ovf_flag_q <= ovf_flag_q | acc_ovf | sq_ovf;
`endif
          end else begin
            res_q     <= acc_q;
            res_vld_q <= 1'b1;
            state_q   <= StIdle;
`ifdef POW_N_OVF_EN
            ovf_q     <= ovf_flag_q;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.n_rdy   = (state_q == StIdle);
  assign bus.res_vld = res_vld_q;
  assign bus.res     = res_q;
`ifdef POW_N_OVF_EN
  assign bus.ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_pow_n_multi_cycle.sv
// Directed bench for pow_n_multi_cycle (W=8, EW=4) with a result scoreboard.
module tb_pow_n_multi_cycle;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_en = 1'b0;

  pow_n_multi_cycle_if #(.W(8), .EW(4)) bus ();

  pow_n_multi_cycle #(.W(8), .EW(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;

  // Reference: repeated multiplication; once a partial product reaches 2**8 the true
  // power does too (base >= 2 grows monotonically; base 0 or 1 never gets there).
  function automatic exp_t model(input logic [7:0] nn, input logic [3:0] ee);
    longint unsigned r = 1;
    longint unsigned t;
    exp_t x;
    x.ovf = 1'b0;
    for (int i = 0; i < int'(ee); i++) begin
      t = r * nn;
      if (t >= 256) x.ovf = 1'b1;
      r = t & 255;
    end
    x.res = r[7:0];
    return x;
  endfunction

  function automatic int bitlen(input logic [3:0] ee);
    int l = 0;
    for (int i = 0; i < 4; i++) if (ee[i]) l = i + 1;
    return l;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [7:0] nn, input logic [3:0] ee, input bit push);
    @(negedge clk);
    bus.n     = nn;
    bus.e     = ee;
    bus.n_vld = 1'b1;
    clk_en    = 1'b1;
    if (push) sb.push_back(model(nn, ee));
  endtask

  // Next posedge is the accepting edge. Optionally chain a second operand with n_vld held.
  task automatic wait_res(input string tag, input logic [3:0] ee, input bit toggle,
                          input bit chain, input logic [7:0] nn2, input logic [3:0] ee2);
    int   cyc = 0;
    bit   seen = 1'b0;
    bit   rdy_hi = 1'b0;
    exp_t x = '0;
    @(posedge clk);
    #1;
    check({tag, ":accept_rdy"}, 32'(bus.n_rdy), 0);
    check({tag, ":accept_vld"}, 32'(bus.res_vld), 0);
    @(negedge clk);
    if (chain) begin
      bus.n = nn2;
      bus.e = ee2;
      sb.push_back(model(nn2, ee2));
    end else begin
      bus.n_vld = 1'b0;
    end
    for (int k = 0; k < 64 && !seen; k++) begin
      if (k > 0) @(negedge clk);
      if (toggle) clk_en = ~clk_en;
      @(posedge clk);
      if (clk_en) cyc++;
      #1;
      if (bus.res_vld) seen = 1'b1;
      else if (bus.n_rdy) rdy_hi = 1'b1;
    end
    check({tag, ":done"}, 32'(seen), 1);
    check({tag, ":latency"}, cyc, bitlen(ee) + 1);
    check({tag, ":rdy_low_in_calc"}, 32'(rdy_hi), 0);
    check({tag, ":rdy_at_done"}, 32'(bus.n_rdy), 1);
    check({tag, ":sb_nonempty"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) x = sb.pop_front();
    check({tag, ":res"}, 32'(bus.res), 32'(x.res));
`ifdef POW_N_OVF_EN
    check({tag, ":ovf"}, 32'(bus.ovf), 32'(x.ovf));
`endif
  endtask

  initial begin
    bit any_vld;
    bus.n_vld = 1'b0;
    bus.n     = '0;
    bus.e     = '0;
    #2 rst = 1'b1;
    #1;
    check("reset:n_rdy", 32'(bus.n_rdy), 1);
    check("reset:res_vld", 32'(bus.res_vld), 0);
    check("reset:res", 32'(bus.res), 0);
`ifdef POW_N_OVF_EN
    check("reset:ovf", 32'(bus.ovf), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    clk_en = 1'b1;

    drive(8'd3, 4'd5, 1'b1);
    wait_res("p3_5", 4'd5, 1'b0, 1'b0, 8'd0, 4'd0);
    drive(8'd3, 4'd6, 1'b1);
    wait_res("p3_6", 4'd6, 1'b0, 1'b0, 8'd0, 4'd0);
    drive(8'd3, 4'd4, 1'b1);
    wait_res("p3_4", 4'd4, 1'b0, 1'b0, 8'd0, 4'd0);
    drive(8'd0, 4'd0, 1'b1);
    wait_res("p0_0", 4'd0, 1'b0, 1'b0, 8'd0, 4'd0);
    drive(8'd7, 4'd0, 1'b1);
    wait_res("p7_0", 4'd0, 1'b0, 1'b0, 8'd0, 4'd0);
    drive(8'd0, 4'd9, 1'b1);
    wait_res("p0_9", 4'd9, 1'b0, 1'b0, 8'd0, 4'd0);

    // clk_en toggling 1010...: completion on the 6th enabled edge counting the accept.
    drive(8'd2, 4'd15, 1'b1);
    wait_res("p2_15_en", 4'd15, 1'b1, 1'b0, 8'd0, 4'd0);
    @(negedge clk);
    clk_en = 1'b0;
    @(posedge clk);
    #1;
    check("p2_15_en:vld_held", 32'(bus.res_vld), 1);
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    check("p2_15_en:vld_clear", 32'(bus.res_vld), 0);

    // Back-to-back with n_vld held high; the second accept is the edge after res_vld.
    drive(8'd2, 4'd7, 1'b1);
    wait_res("b2b_2_7", 4'd7, 1'b0, 1'b1, 8'd5, 4'd3);
    wait_res("b2b_5_3", 4'd3, 1'b0, 1'b0, 8'd0, 4'd0);

    // Reset in flight: op lost, no result pulse.
    drive(8'd3, 4'd5, 1'b0);
    @(posedge clk);
    #1;
    check("rst_mid:accepted", 32'(bus.n_rdy), 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.n_vld = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid:n_rdy", 32'(bus.n_rdy), 1);
    check("rst_mid:res_vld", 32'(bus.res_vld), 0);
    check("rst_mid:res", 32'(bus.res), 0);
`ifdef POW_N_OVF_EN
    check("rst_mid:ovf", 32'(bus.ovf), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    any_vld = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.res_vld) any_vld = 1'b1;
    end
    check("rst_mid:no_res_vld", 32'(any_vld), 0);
    check("rst_mid:idle", 32'(bus.n_rdy), 1);
    drive(8'd2, 4'd3, 1'b1);
    wait_res("p2_3_after_rst", 4'd3, 1'b0, 1'b0, 8'd0, 4'd0);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
